// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler: channel state encoding and
// the minimum effective delay (a requested delay of 0 is clamped to this).
package timer_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } chan_state_e;

  localparam int DELAY_MIN = 1;

endpackage

// File: rtl/timer_sched_chan.sv
// timer_chan: one alarm channel (state, down-count, reload value, periodic bit).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | channel not armed, ticks ignored, o_busy=0
// ST_ARMED | counting ticks down; expires when a tick arrives at count==1
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_arm          arm strobe (request accepted for this channel this edge)
//   i_delay        requested delay in ticks (0 treated as DELAY_MIN)
//   i_periodic     1 = reload and repeat after expiry
//   i_cancel       disarm this edge
//   i_tick         this edge is a tick edge
//   o_busy         channel armed
//   o_expire       one-cycle expiry pulse, registered
module timer_chan
  import timer_sched_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_arm,
  input  logic [WIDTH-1:0] i_delay,
  input  logic             i_periodic,
  input  logic             i_cancel,
  input  logic             i_tick,
  output logic             o_busy,
  output logic             o_expire
);

  chan_state_e      state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             expire_q, expire_d;
  logic [WIDTH-1:0] delay_eff;

  assign delay_eff = (i_delay < WIDTH'(DELAY_MIN)) ? WIDTH'(DELAY_MIN) : i_delay;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      expire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      expire_q   <= expire_d;
    end
  end

  // Priority on a single edge: arm, then cancel, then countdown. An arm on a
  // tick edge therefore does not consume that tick.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    expire_d   = 1'b0;
    if (i_arm) begin
      state_d    = ST_ARMED;
      count_d    = delay_eff;
      reload_d   = delay_eff;
      periodic_d = i_periodic;
    end else if (i_cancel) begin
      state_d = ST_IDLE;
    end else if (i_tick && (state_q == ST_ARMED)) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        expire_d = 1'b1;
        if (periodic_q) begin
          count_d = reload_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  assign o_busy   = (state_q == ST_ARMED);
  assign o_expire = expire_q;

endmodule

// File: rtl/timer_sched.sv
// timer_sched: multi-channel alarm scheduler on one shared prescaler.
// Requesters arm a one-shot or periodic delay (in ticks) through a single
// valid/ready port; each channel emits a one-cycle expire pulse aligned
// with o_tick.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req_valid/o_req_ready  arm handshake (ready is 1 whenever out of reset)
//   i_req_chan        channel to arm; indices >= CHANNELS are swallowed
//   i_req_delay       delay in ticks, 0 treated as 1
//   i_req_periodic    1 = repeat, 0 = one-shot
//   i_cancel          per-channel cancel mask
//   o_tick            one-cycle pulse every 2**PRESCALE clocks
//   o_expire          per-channel expiry pulses
//   o_busy            per-channel armed flags
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CHAN_W   = 2,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 12
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [CHAN_W-1:0]   i_req_chan,
  input  logic [WIDTH-1:0]    i_req_delay,
  input  logic                i_req_periodic,
  input  logic [CHANNELS-1:0] i_cancel,
  output logic                o_tick,
  output logic [CHANNELS-1:0] o_expire,
  output logic [CHANNELS-1:0] o_busy
);

  logic ready_q;
  logic tick_q;
  logic tick_edge;
  logic accept;

  // tick_edge is true on the edge that raises o_tick; the channels count on
  // that same edge so their expire pulse lines up with o_tick.
  generate
    if (PRESCALE == 0) begin : g_no_presc
      assign tick_edge = 1'b1;
    end else begin : g_presc
      logic [PRESCALE-1:0] presc_q;
      always_ff @(posedge i_clk) begin
        if (i_rst) presc_q <= '0;
        else       presc_q <= presc_q + 1'b1;
      end
      assign tick_edge = &presc_q;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ready_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      tick_q  <= tick_edge;
    end
  end

  assign accept = i_req_valid && ready_q;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      logic arm;
      assign arm = accept && (i_req_chan == CHAN_W'(c));

      timer_chan #(
        .WIDTH(WIDTH)
      ) u_chan (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_arm      (arm),
        .i_delay    (i_req_delay),
        .i_periodic (i_req_periodic),
        .i_cancel   (i_cancel[c]),
        .i_tick     (tick_edge),
        .o_busy     (o_busy[c]),
        .o_expire   (o_expire[c])
      );
    end
  endgenerate

  assign o_req_ready = ready_q;
  assign o_tick      = tick_q;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched (PRESCALE=2, WIDTH=8, CHANNELS=4).
// Cycle n is the interval after the n-th rising edge following reset release.
// Stimulus driven in cycle n is sampled at edge n+1. All expected values are
// hand-derived tables indexed by cycle number.
module tb_timer_sched;

  localparam int CH = 4;
  localparam int CW = 2;
  localparam int W  = 8;
  localparam int PS = 2;
  localparam int LAST_CYC = 84;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_chan;
  logic [W-1:0]  req_delay;
  logic          req_periodic;
  logic [CH-1:0] cancel;
  logic          tick;
  logic [CH-1:0] expire;
  logic [CH-1:0] busy;

  int checks   = 0;
  int failures = 0;

  timer_sched #(
    .CHANNELS(CH),
    .CHAN_W  (CW),
    .WIDTH   (W),
    .PRESCALE(PS)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_chan     (req_chan),
    .i_req_delay    (req_delay),
    .i_req_periodic (req_periodic),
    .i_cancel       (cancel),
    .o_tick         (tick),
    .o_expire       (expire),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks every 4 cycles; reset at edge 67 clears o_tick and restarts the
  // prescaler, so the next tick lands 4 cycles after release (cycle 71).
  function automatic logic exp_tick(input int c);
    if (c <= 66)  return (c % 4) == 0;
    if (c == 67)  return 1'b0;
    return ((c - 67) % 4) == 0;
  endfunction

  function automatic logic exp_ready(input int c);
    return c != 67;
  endfunction

  // ch1 periodic D=2 armed edge 2 -> 8, 16 (24 cancelled).
  // ch2 D=0 armed edge 6 -> 8. ch3 D=1 armed on tick edge 4 -> 8.
  // ch0 D=3 armed edge 3 -> 12. ch0 re-armed D=5 + cancelled edge 36 -> 56.
  function automatic logic [CH-1:0] exp_expire(input int c);
    case (c)
      8:       return 4'b1110;
      12:      return 4'b0001;
      16:      return 4'b0010;
      56:      return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [CH-1:0] exp_busy(input int c);
    logic [CH-1:0] b;
    b    = '0;
    b[0] = (c >= 3 && c <= 11) || (c >= 29 && c <= 55) || (c >= 62 && c <= 66);
    b[1] = (c >= 2 && c <= 18) || (c >= 63 && c <= 66);
    b[2] = (c >= 6 && c <= 7)  || (c >= 64 && c <= 66);
    b[3] = (c >= 4 && c <= 7)  || (c >= 65 && c <= 66);
    return b;
  endfunction

  task automatic drive(input int c);
    req_valid    = 1'b0;
    req_chan     = '0;
    req_delay    = '0;
    req_periodic = 1'b0;
    cancel       = '0;
    rst          = 1'b0;
    case (c)
      1:  begin req_valid = 1'b1; req_chan = 2'd1; req_delay = 8'd2; req_periodic = 1'b1; end
      2:  begin req_valid = 1'b1; req_chan = 2'd0; req_delay = 8'd3; end
      3:  begin req_valid = 1'b1; req_chan = 2'd3; req_delay = 8'd1; end
      5:  begin req_valid = 1'b1; req_chan = 2'd2; req_delay = 8'd0; end
      18: cancel = 4'b0010;
      28: begin req_valid = 1'b1; req_chan = 2'd0; req_delay = 8'd2; end
      35: begin req_valid = 1'b1; req_chan = 2'd0; req_delay = 8'd5; cancel = 4'b0001; end
      61, 62, 63, 64: begin
        req_valid    = 1'b1;
        req_chan     = CW'(c - 61);
        req_delay    = 8'd3;
        req_periodic = 1'b1;
      end
      66: rst = 1'b1;
      default: ;
    endcase
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_chan     = '0;
    req_delay    = '0;
    req_periodic = 1'b0;
    cancel       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  32'(req_ready), 32'd0);
    check("rst_tick",   32'(tick),      32'd0);
    check("rst_expire", 32'(expire),    32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    drive(0);
    for (int c = 1; c <= LAST_CYC; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("tick@%0d", c),   32'(tick),      32'(exp_tick(c)));
      check($sformatf("ready@%0d", c),  32'(req_ready), 32'(exp_ready(c)));
      check($sformatf("expire@%0d", c), 32'(expire),    32'(exp_expire(c)));
      check($sformatf("busy@%0d", c),   32'(busy),      32'(exp_busy(c)));
      drive(c);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
- Multi-channel alarm scheduler built around one shared free-running prescaler.
- Lets up to CHANNELS requesters (LED blink sequencers, debounce, UART timeouts) each arm a one-shot or periodic delay through a single valid/ready request port.
- Emits a one-cycle expire pulse per channel.
- Sits between the free-running timebase and the blink/RGB logic on the Fomu board.

Parameters:
- CHANNELS, 4, number of independent alarm channels (1..16).
- CHAN_W, 2, width of channel index; must satisfy 2**CHAN_W >= CHANNELS.
- WIDTH, 16, width of delay and count registers, in ticks.
- PRESCALE, 12, tick period is 2**PRESCALE clocks; 0 means tick every clock.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_req_valid  in  1  arm request valid
- o_req_ready  out  1  arm request accepted when valid&ready
- i_req_chan  in  CHAN_W  channel to arm
- i_req_delay  in  WIDTH  delay in ticks; 0 treated as 1
- i_req_periodic  in  1  1 = reload and repeat; 0 = one-shot
- i_cancel  in  CHANNELS  per-channel cancel mask, sampled every cycle
- o_tick  out  1  one-cycle pulse, once per tick period
- o_expire  out  CHANNELS  one-cycle expiry pulses
- o_busy  out  CHANNELS  channel armed

Behaviour:
- Reset (i_rst high at an edge):
  - Prescaler, all counts, reload values and periodic bits clear to 0.
  - o_tick=0, o_expire=0, o_busy=0, o_req_ready=0.
  - Reset asserted mid-countdown discards all pending alarms; no expire pulse is produced.
- o_req_ready:
  - Registered; 1 from the first edge after i_rst deasserts; 0 only while in reset.
  - Request with i_req_chan >= CHANNELS: accepted (handshake completes) but has no effect.
- Prescaler:
  - PRESCALE-bit counter, increments every clock, wraps.
  - At an edge where it equals 2**PRESCALE-1, o_tick<=1; else o_tick<=0.
  - Result: o_tick is high in cycles 2**PRESCALE, 2*2**PRESCALE, ... after reset release.
  - PRESCALE=0: o_tick=1 every cycle after reset.
- Channel states: IDLE (busy=0), ARMED (busy=1).
- Arm (valid&ready at edge, channel c):
  - count<=max(D,1), reload<=max(D,1), periodic<=i_req_periodic, state<=ARMED.
  - Allowed from either state; re-arming an ARMED channel restarts it.
- Countdown: at a tick edge (the edge that sets o_tick), every ARMED channel not being armed or cancelled at that edge does the following:
  - count>1: count<=count-1.
  - count==1: o_expire[c]<=1. Periodic: count<=reload, stay ARMED. One-shot: state<=IDLE.
- Timing rules:
  - A tick coinciding with the arm edge is not counted. Expire occurs on the D-th tick strictly after acceptance; the o_expire pulse is coincident with the o_tick pulse.
  - o_busy falls in the same cycle o_expire rises (one-shot).
- Cancel: i_cancel[c] at an edge gives state<=IDLE and suppresses any expire from that edge.
- Priority per channel, same edge: arm > cancel > countdown/expire.
- Counts never underflow; max delay is 2**WIDTH-1 ticks.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Shared include timer_sched_defs.vh:
  - State encodings ST_IDLE=1'b0, ST_ARMED=1'b1.
  - Delay-clamp helper constant DELAY_MIN=1.
- Natural sub-module timer_chan: one channel's state, count, reload and periodic bit.
  - Inputs: arm strobe, delay, periodic, cancel, tick.
  - Outputs: busy, expire.
- timer_sched instantiates CHANNELS copies via generate and owns the prescaler, the ready logic and the request decode.

Test Plan (PRESCALE=2, WIDTH=8, CHANNELS=4):
- Reset release, idle -> o_tick high in cycles 4,8,12; o_expire=0, o_busy=0, o_req_ready=1 from cycle 1.
- Arm ch0 one-shot D=3 accepted in cycle 2 -> o_busy[0]=1 from cycle 3. Counts on ticks in cycles 4 and 8; o_expire[0] pulse in cycle 12 with o_tick; o_busy[0]=0 from cycle 12.
- Arm ch1 periodic D=2 in cycle 1 -> o_expire[1] in cycles 8,16,24; busy stays 1. Cancel in cycle 18 -> no pulse at 24, busy=0 from 19.
- Arm ch2 D=0 in cycle 5 -> treated as 1; expire in cycle 8. Arm ch3 D=1 exactly at tick edge (accepted cycle 4) -> that tick ignored; expire in cycle 8.
- Re-arm ch0 D=5 on the same edge it would expire, plus cancel ch0 same edge -> no pulse; busy stays 1; expire 5 ticks later.
- i_rst asserted for 1 cycle with all channels armed -> all busy=0 and o_tick=0 next cycle; no expire pulses afterwards; prescaler restarts (tick 4 cycles after release).
